// File: rtl/diod_pkg.sv
// Shared definitions for the diode bias DAC SPI link: FSM state encodings,
// default word width and the minimum SPI phase length in clk cycles.
package diod_pkg;

  localparam int DIOD_DATA_W      = 8;
  localparam int DIOD_SYNC_STAGES = 2;

  // Receiver FSM encodings; 2'd3 is unused and recovers to IDLE.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Shortest spi_clk phase / ss setup / ss hold the receiver can resolve:
  // the synchronizer depth plus one edge-detect register.
  function automatic int diod_min_phase(input int sync_stages);
    return sync_stages + 1;
  endfunction

  localparam int DIOD_MIN_PHASE = DIOD_SYNC_STAGES + 1;

endpackage

// File: rtl/diod_spi_receiver_if.sv
// SPI bus between diodController (master) and diod_spi_receiver (slave).
// spi_miso exists only when DIOD_SPI_READBACK_EN is defined.
interface diod_spi_receiver_if;

  logic spi_clk;
  logic spi_ss;
  logic spi_mosi;

`ifdef DIOD_SPI_READBACK_EN
  logic spi_miso;

  modport master (output spi_clk, output spi_ss, output spi_mosi, input spi_miso);
  modport slave  (input spi_clk, input spi_ss, input spi_mosi, output spi_miso);
`else
  modport master (output spi_clk, output spi_ss, output spi_mosi);
  modport slave  (input spi_clk, input spi_ss, input spi_mosi);
`endif

endinterface

// File: rtl/diod_sync.sv
// Single-bit multi-flop synchronizer with asynchronous active-low reset.
// Resets to 0 so a line that is already low at reset release never shows
// a falling edge.
module diod_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff_r;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ff_r <= '0;
    end else begin
      ff_r <= {ff_r[STAGES-2:0], d};
    end
  end

  assign q = ff_r[STAGES-1];

endmodule

// File: rtl/diod_spi_receiver.sv
// SPI mode-0 slave receiver for the diode bias DAC link. Oversamples the
// SPI lines in the clk domain, shifts in DATA_W bits MSB first and updates
// the held voltage code only for frames of exactly DATA_W bits.
// Optional feature macro: DIOD_SPI_READBACK_EN (adds spi_miso readback of
// the current voltage code).
module diod_spi_receiver
  import diod_pkg::*;
#(
  parameter int DATA_W      = DIOD_DATA_W,
  parameter int SYNC_STAGES = DIOD_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              reset,
  diod_spi_receiver_if.slave spi,
  output logic [DATA_W-1:0] voltage,
  output logic              data_valid,
  output logic              frame_error,
  output logic              busy,
  output logic [1:0]        debug_state,
  output logic [3:0]        debug_bit_count
);

  // Count must hold 0..DATA_W+1; DATA_W+1 marks an overrun frame.
  localparam int                CNT_W    = $clog2(DATA_W + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_OVR  = CNT_W'(DATA_W + 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  // ---------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------
  logic sclk_q_s;
  logic ss_q_s;
  logic mosi_q_s;

  diod_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk  (clk),
    .reset(reset),
    .d    (spi.spi_clk),
    .q    (sclk_q_s)
  );

  diod_sync #(.STAGES(SYNC_STAGES)) u_sync_ss (
    .clk  (clk),
    .reset(reset),
    .d    (spi.spi_ss),
    .q    (ss_q_s)
  );

  diod_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk  (clk),
    .reset(reset),
    .d    (spi.spi_mosi),
    .q    (mosi_q_s)
  );

  logic sclk_d_r;
  logic ss_d_r;

  // Delayed copies of the synchronized lines for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_d_r <= 1'b0;
      ss_d_r   <= 1'b0;
    end else begin
      sclk_d_r <= sclk_q_s;
      ss_d_r   <= ss_q_s;
    end
  end

  logic sclk_rise_s;
  logic ss_fall_s;
  logic ss_rise_s;

  assign sclk_rise_s = sclk_q_s & ~sclk_d_r;
  assign ss_fall_s   = ~ss_q_s & ss_d_r;
  assign ss_rise_s   = ss_q_s & ~ss_d_r;

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------
  logic [1:0]        state_r,   state_n;
  logic [DATA_W-1:0] shreg_r,   shreg_n;
  logic [CNT_W-1:0]  cnt_r,     cnt_n;
  logic              pend_r,    pend_n;
  logic [DATA_W-1:0] voltage_r, voltage_n;
  logic              dv_r,      dv_n;
  logic              fe_r,      fe_n;
  logic              busy_r;

  // Next-state and datapath decisions for the receive FSM.
  always_comb begin
    state_n   = state_r;
    shreg_n   = shreg_r;
    cnt_n     = cnt_r;
    pend_n    = pend_r;
    voltage_n = voltage_r;
    dv_n      = 1'b0;
    fe_n      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        pend_n = 1'b0;
        if (ss_fall_s || pend_r) begin
          state_n = ST_SHIFT;
          shreg_n = '0;
          cnt_n   = '0;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        pend_n = 1'b0;
        // End of frame has priority over a coincident clock edge.
        if (ss_rise_s) begin
          state_n = ST_DONE;
        end else if (sclk_rise_s) begin
          shreg_n = {shreg_r[DATA_W-2:0], mosi_q_s};
          if (cnt_r != CNT_OVR) begin
            cnt_n = cnt_r + CNT_ONE;
          end else begin
            cnt_n = cnt_r;
          end
        end else begin
          state_n = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        // A new frame can start while we are still judging the old one.
        pend_n  = ss_fall_s;
        if (cnt_r == CNT_FULL) begin
          voltage_n = shreg_r;
          dv_n      = 1'b1;
        end else if (cnt_r != '0) begin
          fe_n = 1'b1;
        end else begin
          fe_n = 1'b0;
        end
      end
      default: begin
        state_n = ST_IDLE;
        pend_n  = 1'b0;
      end
    endcase
  end

  // Register FSM state, datapath and all outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      shreg_r   <= '0;
      cnt_r     <= '0;
      pend_r    <= 1'b0;
      voltage_r <= '0;
      dv_r      <= 1'b0;
      fe_r      <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_n;
      shreg_r   <= shreg_n;
      cnt_r     <= cnt_n;
      pend_r    <= pend_n;
      voltage_r <= voltage_n;
      dv_r      <= dv_n;
      fe_r      <= fe_n;
      busy_r    <= (state_n == ST_SHIFT);
    end
  end

  assign voltage         = voltage_r;
  assign data_valid      = dv_r;
  assign frame_error     = fe_r;
  assign busy            = busy_r;
  assign debug_state     = state_r;
  assign debug_bit_count = 4'(cnt_r);

`ifdef DIOD_SPI_READBACK_EN
  // ---------------------------------------------------------------------
  // Readback: shift the held code out on spi_miso, MSB first.
  // ---------------------------------------------------------------------
  logic              sclk_fall_s;
  logic [DATA_W-1:0] rb_r;

  assign sclk_fall_s = ~sclk_q_s & sclk_d_r;

  // Load on frame start (using the code that is about to be held, so a
  // back-to-back frame reads the freshest value), shift on each clock fall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rb_r <= '0;
    end else if (ss_fall_s) begin
      rb_r <= voltage_n;
    end else if (ss_q_s) begin
      rb_r <= '0;
    end else if (sclk_fall_s) begin
      rb_r <= {rb_r[DATA_W-2:0], 1'b0};
    end else begin
      rb_r <= rb_r;
    end
  end

  assign spi.spi_miso = rb_r[DATA_W-1];
`endif

endmodule
